// File: rtl/osd_window_ctrl_if.sv
// OSD bitmap RAM port: req/addr held until a 1-cycle ack with data.
// master = OSD controller, slave = shared RAM arbiter.
interface osd_window_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [7:0]        data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/osd_window_ctrl.sv
// OSD sequencer: measures the active raster, centres an OSD_W x OSD_H
// window in it, fetches bitmap bytes over mem and serialises them.
// Ports: CLK_VIDEO, RESET_N (async, low), ce_pix, hsync/vsync/hblank/vblank,
//   enable, bkgr_in[2:0] (sampled at vsync rise), mem (bitmap port, master),
//   osd_window, osd_pixel, osd_bkgr[2:0], underrun (sticky).
// Option: OSD_DOUBLE_Y_EN shows every bitmap line on two raster lines.
module osd_window_ctrl #(
    parameter int OSD_W  = 256,
    parameter int OSD_H  = 64,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 12
) (
    input  logic              CLK_VIDEO,
    input  logic              RESET_N,
    input  logic              ce_pix,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              enable,
    input  logic [2:0]        bkgr_in,
    osd_window_ctrl_if.master mem,
    output logic              osd_window,
    output logic              osd_pixel,
    output logic [2:0]        osd_bkgr,
    output logic              underrun
);

`ifdef OSD_DOUBLE_Y_EN
    localparam int DY = 1;
`else
    localparam int DY = 0;
`endif

    localparam int WIN_H = OSD_H << DY;
    localparam int BPL   = OSD_W / 8;
    localparam int BIW   = $clog2(BPL + 1);

    localparam logic [CNT_W-1:0]  CMAX    = '1;
    localparam logic [CNT_W-1:0]  OSD_W_N = CNT_W'(OSD_W);
    localparam logic [CNT_W-1:0]  WIN_H_N = CNT_W'(WIN_H);
    localparam logic [CNT_W:0]    OSD_W_C = (CNT_W+1)'(OSD_W);
    localparam logic [CNT_W:0]    WIN_H_C = (CNT_W+1)'(WIN_H);
    localparam logic [BIW-1:0]    BPL_C   = BIW'(BPL);
    localparam logic [ADDR_W-1:0] BPL_A   = ADDR_W'(BPL);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic             hblank_d;
    logic             vsync_d;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             line_act;
    logic [CNT_W-1:0] act_w;
    logic [CNT_W-1:0] h_start;
    logic [CNT_W-1:0] v_start;
    logic             en_f;

    logic [0:0]       state;
    logic [BIW-1:0]   byte_idx;
    logic [7:0]       pf;
    logic             pf_valid;
    logic             discard;
    logic [7:0]       sr;
    logic [3:0]       bc;

    logic             hb_rise;
    logic             vs_rise;
    logic             de;
    logic             pix;
    logic [CNT_W-1:0] hcnt_inc;
    logic             line_done;
    logic [CNT_W-1:0] act_h;
    logic [CNT_W-1:0] act_w_now;
    logic [CNT_W:0]   h_end;
    logic [CNT_W:0]   v_end;
    logic             in_v;
    logic             in_h;
    logic             win;
    logic             wpix;
    logic             need_load;
    logic [CNT_W-1:0] rel;
    logic [CNT_W-1:0] line_idx;
    logic             fetch_go;
    logic             ack_ok;
    logic             edge_clr;
    logic             unused_sig;

    assign unused_sig = hsync;

    assign hb_rise  = hblank & ~hblank_d;
    assign vs_rise  = vsync & ~vsync_d;
    assign edge_clr = hb_rise | vs_rise;
    assign de       = ~hblank & ~vblank;
    assign pix      = ce_pix & de;
    assign hcnt_inc = (hcnt == CMAX) ? hcnt : hcnt + 1'b1;

    // vcnt doubles as the active-line count; include a line that ends
    // on the very cycle vsync rises.
    assign line_done = hb_rise & line_act;
    assign act_h     = (line_done && vcnt != CMAX) ? vcnt + 1'b1 : vcnt;
    assign act_w_now = (pix && hcnt_inc > act_w) ? hcnt_inc : act_w;

    assign h_end = {1'b0, h_start} + OSD_W_C;
    assign v_end = {1'b0, v_start} + WIN_H_C;
    assign in_v  = en_f & (vcnt >= v_start) & ({1'b0, vcnt} < v_end);
    assign in_h  = (hcnt >= h_start) & ({1'b0, hcnt} < h_end);
    assign win   = in_v & de & in_h;
    assign wpix  = win & ce_pix;

    assign need_load = wpix & ((hcnt == h_start) | (bc == 4'd0));

    assign rel      = vcnt - v_start;
    assign line_idx = rel >> DY;

    // No launch on a line/frame edge: the request would carry stale
    // line and byte indices that the edge is about to reset.
    assign fetch_go = (state == S_IDLE) & in_v & ~pf_valid
                    & (byte_idx < BPL_C) & ~edge_clr;
    assign ack_ok   = (state == S_REQ) & mem.ack;

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            hblank_d <= 1'b0;
            vsync_d  <= 1'b0;
            hcnt     <= '0;
            vcnt     <= '0;
            line_act <= 1'b0;
            act_w    <= '0;
            h_start  <= '0;
            v_start  <= '0;
            en_f     <= 1'b0;
            osd_bkgr <= '0;
        end else begin
            hblank_d <= hblank;
            vsync_d  <= vsync;
            if (hb_rise) begin
                hcnt     <= '0;
                line_act <= 1'b0;
                vcnt     <= act_h;
            end else if (pix) begin
                hcnt     <= hcnt_inc;
                line_act <= 1'b1;
                if (hcnt_inc > act_w) begin
                    act_w <= hcnt_inc;
                end
            end
            if (vs_rise) begin
                h_start  <= (act_w_now - OSD_W_N) >> 1;
                v_start  <= (act_h - WIN_H_N) >> 1;
                en_f     <= enable & (act_w_now >= OSD_W_N)
                          & (act_h >= WIN_H_N);
                osd_bkgr <= bkgr_in;
                vcnt     <= '0;
                act_w    <= '0;
                line_act <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            mem.req    <= 1'b0;
            mem.addr   <= '0;
            byte_idx   <= '0;
            pf         <= '0;
            pf_valid   <= 1'b0;
            discard    <= 1'b0;
            sr         <= '0;
            bc         <= '0;
            osd_window <= 1'b0;
            osd_pixel  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (fetch_go) begin
                        state    <= S_REQ;
                        mem.req  <= 1'b1;
                        mem.addr <= ADDR_W'(line_idx) * BPL_A
                                  + ADDR_W'(byte_idx);
                    end
                end
                (state == S_REQ): begin
                    if (mem.ack) begin
                        state   <= S_IDLE;
                        mem.req <= 1'b0;
                    end
                end
            endcase

            // Load consumes the old pf first; a same-cycle ack refills it.
            if (need_load && pf_valid) begin
                pf_valid <= 1'b0;
            end
            if (ack_ok) begin
                discard <= 1'b0;
                if (!discard && !edge_clr) begin
                    pf       <= mem.data;
                    pf_valid <= 1'b1;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
            // A request still in flight across a line edge is drained,
            // and its byte dropped when the ack eventually comes.
            if (edge_clr) begin
                byte_idx <= '0;
                pf_valid <= 1'b0;
                if (state == S_REQ && !mem.ack) begin
                    discard <= 1'b1;
                end
            end

            if (ce_pix) begin
                osd_window <= win;
                osd_pixel  <= 1'b0;
                if (win) begin
                    if (need_load) begin
                        if (pf_valid) begin
                            sr        <= {pf[6:0], 1'b0};
                            bc        <= 4'd7;
                            osd_pixel <= pf[7];
                        end else begin
                            bc       <= 4'd0;
                            underrun <= 1'b1;
                        end
                    end else begin
                        sr        <= {sr[6:0], 1'b0};
                        bc        <= bc - 1'b1;
                        osd_pixel <= sr[7];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_osd_window_ctrl.sv
// Scoreboard bench for osd_window_ctrl: 320-wide raster, small OSD height.
// Expected window/pixel/address values are queued as stimulus is driven.
module tb_osd_window_ctrl;

    localparam int OW  = 256;
    localparam int OH  = 4;
    localparam int AW  = 11;
    localparam int CW  = 12;
`ifdef OSD_DOUBLE_Y_EN
    localparam int DY  = 1;
`else
    localparam int DY  = 0;
`endif
    localparam int WH  = OH << DY;
    localparam int BPL = OW / 8;
    localparam int HB  = 40;
    localparam int NB  = BPL * OH;

    typedef struct {
        bit win;
        bit pix;
        bit cp;
        int l;
        int p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce_pix, hsync, vsync, hblank, vblank, enable;
    logic [2:0] bkgr_in;
    logic       osd_window, osd_pixel, underrun;
    logic [2:0] osd_bkgr;

    osd_window_ctrl_if #(.ADDR_W(AW)) mem_if ();

    osd_window_ctrl #(
        .OSD_W(OW), .OSD_H(OH), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .CLK_VIDEO (clk),
        .RESET_N   (rst_n),
        .ce_pix    (ce_pix),
        .hsync     (hsync),
        .vsync     (vsync),
        .hblank    (hblank),
        .vblank    (vblank),
        .enable    (enable),
        .bkgr_in   (bkgr_in),
        .mem       (mem_if),
        .osd_window(osd_window),
        .osd_pixel (osd_pixel),
        .osd_bkgr  (osd_bkgr),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sbq[$];
    int unsigned aq[$];
    logic [7:0]  bm [NB];
    int          ack_dly = 1;
    bit          addr_chk = 1'b0;
    bit          m_en = 1'b0;
    int          m_hs = 0;
    int          m_vs = 0;
    bit          ur_exp = 1'b0;
    logic [2:0]  bk_exp = 3'd0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // RAM model: ack ack_dly cycles after req is seen, data from bm.
    initial begin
        int w;
        w = 0;
        mem_if.ack  = 1'b0;
        mem_if.data = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_if.ack) begin
                mem_if.ack = 1'b0;
                w = 0;
            end else if (mem_if.req === 1'b1) begin
                if (w >= ack_dly) begin
                    mem_if.ack  = 1'b1;
                    mem_if.data = bm[int'(mem_if.addr) % NB];
                    if (addr_chk) begin
                        if (aq.size() == 0)
                            check("addr_spurious", mem_if.req, 1'b0);
                        else
                            check("addr", mem_if.addr, aq.pop_front());
                    end
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    task automatic step(input bit act, input bit hb, input bit vb,
                        input bit vs, input bit hs, input int l,
                        input int p, input bit cp);
        exp_t       e, o;
        int         li, bi;
        logic [7:0] b;
        @(negedge clk);
        if (sbq.size() > 0) begin
            o = sbq.pop_front();
            check($sformatf("win l%0d p%0d", o.l, o.p), osd_window, o.win);
            if (o.cp || !o.win)
                check($sformatf("pix l%0d p%0d", o.l, o.p), osd_pixel, o.pix);
        end
        ce_pix = 1'b1;
        hblank = hb;
        vblank = vb;
        vsync  = vs;
        hsync  = hs;
        e.win = act && m_en && l >= m_vs && l < m_vs + WH
                && p >= m_hs && p < m_hs + OW;
        e.pix = 1'b0;
        if (e.win) begin
            li = (l - m_vs) >> DY;
            bi = p - m_hs;
            b  = bm[li * BPL + bi / 8];
            e.pix = b[7 - bi % 8];
        end
        e.cp = cp;
        e.l  = l;
        e.p  = p;
        sbq.push_back(e);
    endtask

    task automatic line(input int w, input int l, input bit vb,
                        input bit vs, input bit cp);
        for (int p = 0; p < w; p++)
            step(!vb, 1'b0, vb, vs, 1'b0, l, p, cp);
        for (int k = 0; k < HB; k++)
            step(1'b0, 1'b1, vb, vs, (k >= 8 && k < 24), l, w + k, cp);
    endtask

    task automatic frame(input int w, input int h, input bit en0,
                         input bit en1, input int dly, input bit cp,
                         input bit ca, input logic [2:0] bk);
        enable   = en0;
        ack_dly  = dly;
        bkgr_in  = bk;
        aq.delete();
        addr_chk = ca;
        if (ca && m_en)
            for (int r = 0; r < WH; r++)
                for (int b = 0; b < BPL; b++)
                    aq.push_back((r >> DY) * BPL + b);
        if (dly > 8 && m_en)
            ur_exp = 1'b1;
        for (int l = 0; l < h; l++) begin
            if (l == h / 2)
                enable = en1;
            line(w, l, 1'b0, 1'b0, cp);
        end
        line(w, h, 1'b1, 1'b0, cp);
        m_en   = enable && w >= OW && h >= WH;
        m_hs   = (w - OW) / 2;
        m_vs   = (h - WH) / 2;
        bk_exp = bk;
        line(w, h + 1, 1'b1, 1'b1, cp);
        line(w, h + 2, 1'b1, 1'b0, cp);
        if (ca)
            check("addr_left", aq.size(), 0);
        check("bkgr", osd_bkgr, bk_exp);
        check("underrun", underrun, ur_exp);
    endtask

    initial begin
        for (int i = 0; i < NB; i++)
            bm[i] = 8'($urandom);
        bm[0] = 8'hA5;
        ce_pix  = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        hblank  = 1'b1;
        vblank  = 1'b1;
        enable  = 1'b0;
        bkgr_in = 3'd7;

        repeat (3) @(negedge clk);
        check("rst_win", osd_window, 1'b0);
        check("rst_pix", osd_pixel, 1'b0);
        check("rst_bkgr", osd_bkgr, 3'd0);
        check("rst_ur", underrun, 1'b0);
        check("rst_req", mem_if.req, 1'b0);
        check("rst_addr", mem_if.addr, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("idle_req", mem_if.req, 1'b0);
            check("idle_win", osd_window, 1'b0);
        end

        frame(320, 12, 1, 1, 1, 1, 1, 3'd1);
        frame(320, 12, 1, 1, 1, 1, 1, 3'd2);
        frame(320, 12, 1, 0, 1, 1, 1, 3'd3);
        frame(320, 12, 1, 1, 1, 1, 1, 3'd4);
        frame(320, 12, 1, 1, 20, 0, 0, 3'd5);
        frame(320, 12, 1, 1, 1, 1, 1, 3'd6);
        frame(200, 12, 1, 1, 1, 1, 0, 3'd2);
        frame(320, 12, 1, 1, 1, 1, 1, 3'd1);
        frame(320, 12, 1, 1, 1, 1, 1, 3'd5);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_ur", underrun, 1'b0);
        check("rst2_bkgr", osd_bkgr, 3'd0);
        check("rst2_req", mem_if.req, 1'b0);
        check("rst2_win", osd_window, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
